// File: rtl/id_alu_decode.sv
// RV32I decode stage: registers the decoded ALU control word, immediates, register
// indices and control strobes for one instruction, with stall/flush handling.
module id_alu_decode #(
  parameter bit ILLEGAL_AS_NOP = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_valid,
  input  logic [31:0] if_inst,
  input  logic [31:0] if_pc,
  input  logic        stall,
  input  logic        flush,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [4:0]  id_alu_ctrl,
  output logic        id_alu_src1_pc,
  output logic        id_alu_src2_imm,
  output logic [31:0] id_imm,
  output logic [4:0]  id_rs1,
  output logic [4:0]  id_rs2,
  output logic [4:0]  id_rd,
  output logic        id_reg_write,
  output logic        id_mem_read,
  output logic        id_mem_write,
  output logic [2:0]  id_funct3,
  output logic        id_is_branch,
  output logic        id_is_jal,
  output logic        id_is_jalr,
  output logic        id_illegal
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  localparam logic [4:0] ALU_PASS = 5'd0,  ALU_ADD  = 5'd1,  ALU_SUB  = 5'd2,  ALU_SLT  = 5'd3;
  localparam logic [4:0] ALU_SLTU = 5'd4,  ALU_SLL  = 5'd5,  ALU_SRA  = 5'd6,  ALU_SRL  = 5'd7;
  localparam logic [4:0] ALU_AND  = 5'd8,  ALU_OR   = 5'd9,  ALU_XOR  = 5'd10, ALU_BEQ  = 5'd11;
  localparam logic [4:0] ALU_BNE  = 5'd12, ALU_BLT  = 5'd13, ALU_BLTU = 5'd14, ALU_BGE  = 5'd15;
  localparam logic [4:0] ALU_BGEU = 5'd16;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  ctrl;
    logic        src1_pc;
    logic        src2_imm;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic        is_branch;
    logic        is_jal;
    logic        is_jalr;
    logic        illegal;
  } id_word_t;

  logic [6:0]  opcode;
  logic [6:0]  funct7;
  logic [2:0]  funct3;
  logic [4:0]  rs1_f;
  logic [4:0]  rs2_f;
  logic [4:0]  rd_f;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;
  logic        writes_rd;
  id_word_t    dec;
  id_word_t    q;

  assign opcode = if_inst[6:0];
  assign funct7 = if_inst[31:25];
  assign funct3 = if_inst[14:12];
  assign rs1_f  = if_inst[19:15];
  assign rs2_f  = if_inst[24:20];
  assign rd_f   = if_inst[11:7];

  assign imm_i = {{20{if_inst[31]}}, if_inst[31:20]};
  assign imm_s = {{20{if_inst[31]}}, if_inst[31:25], if_inst[11:7]};
  assign imm_b = {{19{if_inst[31]}}, if_inst[31], if_inst[7], if_inst[30:25], if_inst[11:8], 1'b0};
  assign imm_u = {if_inst[31:12], 12'b0};
  assign imm_j = {{11{if_inst[31]}}, if_inst[31], if_inst[19:12], if_inst[20], if_inst[30:21], 1'b0};

  function automatic logic [4:0] alu_of_funct3(input logic [2:0] f);
    case (f)
      3'b000:  return ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  always_comb begin
    dec        = '0;
    writes_rd  = 1'b0;
    dec.valid  = 1'b1;
    dec.pc     = if_pc;
    dec.funct3 = funct3;
    case (opcode)
      OPC_OP: begin
        dec.rs1   = rs1_f;
        dec.rs2   = rs2_f;
        writes_rd = 1'b1;
        if (funct7 == F7_BASE)                          dec.ctrl = alu_of_funct3(funct3);
        else if (funct7 == F7_ALT && funct3 == 3'b000)  dec.ctrl = ALU_SUB;
        else if (funct7 == F7_ALT && funct3 == 3'b101)  dec.ctrl = ALU_SRA;
        else                                            dec.illegal = 1'b1;
      end
      OPC_OP_IMM: begin
        dec.rs1      = rs1_f;
        dec.src2_imm = 1'b1;
        writes_rd    = 1'b1;
        dec.ctrl     = alu_of_funct3(funct3);
        dec.imm      = imm_i;
        // Shift forms reuse the upper immediate bits as a funct7 qualifier.
        if (funct3 == 3'b001) begin
          dec.imm = {27'b0, rs2_f};
          if (funct7 != F7_BASE) dec.illegal = 1'b1;
        end else if (funct3 == 3'b101) begin
          dec.imm = {27'b0, rs2_f};
          if (funct7 == F7_BASE)     dec.ctrl    = ALU_SRL;
          else if (funct7 == F7_ALT) dec.ctrl    = ALU_SRA;
          else                       dec.illegal = 1'b1;
        end
      end
      OPC_LUI: begin
        dec.ctrl     = ALU_PASS;
        dec.src2_imm = 1'b1;
        dec.imm      = imm_u;
        writes_rd    = 1'b1;
      end
      OPC_AUIPC: begin
        dec.ctrl     = ALU_ADD;
        dec.src1_pc  = 1'b1;
        dec.src2_imm = 1'b1;
        dec.imm      = imm_u;
        writes_rd    = 1'b1;
      end
      OPC_JAL: begin
        dec.ctrl     = ALU_ADD;
        dec.src1_pc  = 1'b1;
        dec.src2_imm = 1'b1;
        dec.imm      = imm_j;
        dec.is_jal   = 1'b1;
        writes_rd    = 1'b1;
      end
      OPC_JALR: begin
        dec.ctrl     = ALU_ADD;
        dec.rs1      = rs1_f;
        dec.src2_imm = 1'b1;
        dec.imm      = imm_i;
        dec.is_jalr  = 1'b1;
        writes_rd    = 1'b1;
        if (funct3 != 3'b000) dec.illegal = 1'b1;
      end
      OPC_BRANCH: begin
        dec.rs1       = rs1_f;
        dec.rs2       = rs2_f;
        dec.imm       = imm_b;
        dec.is_branch = 1'b1;
        case (funct3)
          3'b000:  dec.ctrl    = ALU_BEQ;
          3'b001:  dec.ctrl    = ALU_BNE;
          3'b100:  dec.ctrl    = ALU_BLT;
          3'b110:  dec.ctrl    = ALU_BLTU;
          3'b101:  dec.ctrl    = ALU_BGE;
          3'b111:  dec.ctrl    = ALU_BGEU;
          default: dec.illegal = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        dec.ctrl     = ALU_ADD;
        dec.rs1      = rs1_f;
        dec.src2_imm = 1'b1;
        dec.imm      = imm_i;
        dec.mem_read = 1'b1;
        writes_rd    = 1'b1;
        if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111) dec.illegal = 1'b1;
      end
      OPC_STORE: begin
        dec.ctrl      = ALU_ADD;
        dec.rs1       = rs1_f;
        dec.rs2       = rs2_f;
        dec.src2_imm  = 1'b1;
        dec.imm       = imm_s;
        dec.mem_write = 1'b1;
        if (funct3[2] || funct3 == 3'b011) dec.illegal = 1'b1;
      end
      default: dec.illegal = 1'b1;
    endcase

    // An illegal word keeps only its identity (pc, funct3) plus the illegal flag.
    if (dec.illegal) begin
      dec         = '0;
      dec.valid   = 1'b1;
      dec.pc      = if_pc;
      dec.funct3  = funct3;
      dec.illegal = 1'b1;
      if (!ILLEGAL_AS_NOP) begin
        dec.rd        = rd_f;
        dec.reg_write = |rd_f;
      end
    end else if (writes_rd) begin
      dec.rd        = rd_f;
      dec.reg_write = |rd_f;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      q <= '0;
    end else if (!stall) begin
      q <= if_valid ? dec : '0;
    end
  end

  assign id_valid        = q.valid;
  assign id_pc           = q.pc;
  assign id_alu_ctrl     = q.ctrl;
  assign id_alu_src1_pc  = q.src1_pc;
  assign id_alu_src2_imm = q.src2_imm;
  assign id_imm          = q.imm;
  assign id_rs1          = q.rs1;
  assign id_rs2          = q.rs2;
  assign id_rd           = q.rd;
  assign id_reg_write    = q.reg_write;
  assign id_mem_read     = q.mem_read;
  assign id_mem_write    = q.mem_write;
  assign id_funct3       = q.funct3;
  assign id_is_branch    = q.is_branch;
  assign id_is_jal       = q.is_jal;
  assign id_is_jalr      = q.is_jalr;
  assign id_illegal      = q.illegal;

endmodule

// File: tb/tb_id_alu_decode.sv
// Randomized bench for id_alu_decode: a mnemonic-level reference model predicts every
// registered output each cycle, and a few hand-worked encodings pin that model down.
module tb_id_alu_decode;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  ctrl;
    logic        src1_pc;
    logic        src2_imm;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic        is_branch;
    logic        is_jal;
    logic        is_jalr;
    logic        illegal;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, if_valid, stall, flush;
  logic [31:0] if_inst, if_pc;
  logic        id_valid, id_alu_src1_pc, id_alu_src2_imm, id_reg_write, id_mem_read, id_mem_write;
  logic        id_is_branch, id_is_jal, id_is_jalr, id_illegal;
  logic [31:0] id_pc, id_imm;
  logic [4:0]  id_alu_ctrl, id_rs1, id_rs2, id_rd;
  logic [2:0]  id_funct3;

  exp_t act;
  exp_t expected = '0;
  bit   cmp_en = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  id_alu_decode dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc),
    .stall(stall), .flush(flush), .id_valid(id_valid), .id_pc(id_pc),
    .id_alu_ctrl(id_alu_ctrl), .id_alu_src1_pc(id_alu_src1_pc),
    .id_alu_src2_imm(id_alu_src2_imm), .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_funct3(id_funct3), .id_is_branch(id_is_branch),
    .id_is_jal(id_is_jal), .id_is_jalr(id_is_jalr), .id_illegal(id_illegal)
  );

  assign act = {id_valid, id_pc, id_alu_ctrl, id_alu_src1_pc, id_alu_src2_imm, id_imm,
                id_rs1, id_rs2, id_rd, id_reg_write, id_mem_read, id_mem_write, id_funct3,
                id_is_branch, id_is_jal, id_is_jalr, id_illegal};

  always #5 clk = ~clk;

  // Reference decode by instruction class, from the ISA field definitions.
  function automatic exp_t model(input logic [31:0] i, input logic [31:0] pc);
    exp_t        o = '0;
    int          op_tab[8] = '{1, 5, 3, 4, 10, 7, 9, 8};
    int          br_tab[8] = '{11, 12, -1, -1, 13, 15, 14, 16};
    int          f3 = int'(i[14:12]);
    int          f7 = int'(i[31:25]);
    bit          legal = 1'b1;
    bit          writes = 1'b0;
    logic [12:0] braw = {i[31], i[7], i[30:25], i[11:8], 1'b0};
    logic [20:0] jraw = {i[31], i[19:12], i[20], i[30:21], 1'b0};
    logic [11:0] sraw = {i[31:25], i[11:7]};
    logic [31:0] imm_i = 32'($signed(i) >>> 20);
    logic [31:0] imm_s = 32'($signed(sraw));
    logic [31:0] imm_b = 32'($signed(braw));
    logic [31:0] imm_j = 32'($signed(jraw));
    logic [31:0] imm_u = i & 32'hFFFF_F000;
    o.valid = 1'b1;
    o.pc = pc;
    o.funct3 = i[14:12];
    case (i[6:0])
      7'h33: begin
        o.rs1 = i[19:15]; o.rs2 = i[24:20]; writes = 1;
        if (f7 == 0) o.ctrl = 5'(op_tab[f3]);
        else if (f7 == 32 && f3 == 0) o.ctrl = 2;
        else if (f7 == 32 && f3 == 5) o.ctrl = 6;
        else legal = 0;
      end
      7'h13: begin
        o.rs1 = i[19:15]; o.src2_imm = 1; writes = 1;
        o.ctrl = 5'(op_tab[f3]); o.imm = imm_i;
        if (f3 == 1 || f3 == 5) o.imm = 32'(i[24:20]);
        if (f3 == 1 && f7 != 0) legal = 0;
        if (f3 == 5) begin
          if (f7 == 32) o.ctrl = 6;
          else if (f7 != 0) legal = 0;
        end
      end
      7'h37: begin o.ctrl = 0; o.src2_imm = 1; o.imm = imm_u; writes = 1; end
      7'h17: begin o.ctrl = 1; o.src1_pc = 1; o.src2_imm = 1; o.imm = imm_u; writes = 1; end
      7'h6F: begin
        o.ctrl = 1; o.src1_pc = 1; o.src2_imm = 1; o.imm = imm_j; o.is_jal = 1; writes = 1;
      end
      7'h67: begin
        o.ctrl = 1; o.rs1 = i[19:15]; o.src2_imm = 1; o.imm = imm_i; o.is_jalr = 1; writes = 1;
        if (f3 != 0) legal = 0;
      end
      7'h63: begin
        o.rs1 = i[19:15]; o.rs2 = i[24:20]; o.imm = imm_b; o.is_branch = 1;
        if (br_tab[f3] < 0) legal = 0; else o.ctrl = 5'(br_tab[f3]);
      end
      7'h03: begin
        o.ctrl = 1; o.rs1 = i[19:15]; o.src2_imm = 1; o.imm = imm_i; o.mem_read = 1; writes = 1;
        if (!(f3 inside {0, 1, 2, 4, 5})) legal = 0;
      end
      7'h23: begin
        o.ctrl = 1; o.rs1 = i[19:15]; o.rs2 = i[24:20]; o.src2_imm = 1; o.imm = imm_s;
        o.mem_write = 1;
        if (f3 > 2) legal = 0;
      end
      default: legal = 0;
    endcase
    if (!legal) begin
      o = '0; o.valid = 1; o.pc = pc; o.funct3 = i[14:12]; o.illegal = 1;
    end else if (writes) begin
      o.rd = i[11:7]; o.reg_write = (i[11:7] != 0);
    end
    return o;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] r = $urandom;
    int k = $urandom_range(0, 9);
    case (k)
      0: begin r[6:0] = 7'h33; if ($urandom_range(0, 3) != 0) r[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00; end
      1: begin r[6:0] = 7'h13; if ($urandom_range(0, 3) != 0) r[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00; end
      2: r[6:0] = 7'h37;
      3: r[6:0] = 7'h17;
      4: r[6:0] = 7'h6F;
      5: begin r[6:0] = 7'h67; if ($urandom_range(0, 3) != 0) r[14:12] = 3'b000; end
      6: r[6:0] = 7'h63;
      7: r[6:0] = 7'h03;
      8: r[6:0] = 7'h23;
      default: ;
    endcase
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst || flush) expected <= '0;
    else if (!stall) expected <= if_valid ? model(if_inst, if_pc) : '0;
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      n_vec++;
      if (act !== expected) begin
        n_err++;
        $display("[TB] FAIL cycle_compare @%0t: dut=%h model=%h", $time, act, expected);
      end
    end
  end

  task automatic apply_stimulus(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                                input logic st, input logic fl, input logic r);
    @(negedge clk);
    if_valid = v; if_inst = inst; if_pc = pc; stall = st; flush = fl; rst = r;
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, got, want);
    end
  endtask

  initial begin
    rst = 1'b1; if_valid = 1'b0; if_inst = '0; if_pc = '0; stall = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cmp_en = 1'b1;
    check_output("reset_valid", 32'(id_valid), 32'd0);
    check_output("reset_pc", id_pc, 32'd0);

    apply_stimulus(1, 32'h002081B3, 32'h100, 0, 0, 0);
    check_output("add_valid", 32'(id_valid), 32'd1);
    check_output("add_ctrl", 32'(id_alu_ctrl), 32'd1);
    check_output("add_regs", {17'd0, id_rs1, id_rs2, id_rd}, {17'd0, 5'd1, 5'd2, 5'd3});
    check_output("add_wr_src2", {30'd0, id_reg_write, id_alu_src2_imm}, 32'b10);

    apply_stimulus(1, 32'h40335293, 32'h104, 0, 0, 0);
    check_output("srai_ctrl", 32'(id_alu_ctrl), 32'd6);
    check_output("srai_imm", id_imm, 32'h3);
    check_output("srai_src2", 32'(id_alu_src2_imm), 32'd1);
    apply_stimulus(1, 32'h40331293, 32'h108, 0, 0, 0);
    check_output("bad_slli_illegal", 32'(id_illegal), 32'd1);

    apply_stimulus(1, 32'hFE20DEE3, 32'h10C, 0, 0, 0);
    check_output("bge_ctrl", 32'(id_alu_ctrl), 32'd15);
    check_output("bge_imm", id_imm, 32'hFFFF_FFFC);
    check_output("bge_flags", {27'd0, id_is_branch, id_reg_write, id_rd}, {27'd0, 1'b1, 1'b0, 5'd0});

    apply_stimulus(1, 32'h123453B7, 32'h110, 0, 0, 0);
    check_output("lui_ctrl", 32'(id_alu_ctrl), 32'd0);
    check_output("lui_imm", id_imm, 32'h1234_5000);
    apply_stimulus(1, 32'h00001097, 32'h114, 0, 0, 0);
    check_output("auipc_ctrl_src1", {26'd0, id_alu_ctrl, id_alu_src1_pc}, {26'd0, 5'd1, 1'b1});

    apply_stimulus(1, 32'h002081B3, 32'h200, 0, 0, 0);
    for (int s = 0; s < 3; s++) begin
      apply_stimulus(1, 32'h123453B7, 32'h300 + 32'(4 * s), 1, 0, 0);
      check_output("stall_hold_pc", id_pc, 32'h200);
      check_output("stall_hold_ctrl_rd", {22'd0, id_alu_ctrl, id_rd}, {22'd0, 5'd1, 5'd3});
    end
    apply_stimulus(1, 32'h123453B7, 32'h310, 1, 1, 0);
    check_output("stall_flush_bubble", {id_pc[30:0], id_valid}, 32'd0);
    apply_stimulus(1, 32'h002081B3, 32'h314, 0, 0, 0);
    apply_stimulus(0, 32'h002081B3, 32'h318, 0, 0, 0);
    check_output("invalid_bubble", 32'(id_valid), 32'd0);
    apply_stimulus(1, 32'hFFFF_FFFF, 32'h31C, 0, 0, 0);
    check_output("ones_illegal", {29'd0, id_valid, id_illegal, id_reg_write}, 32'b110);
    apply_stimulus(1, 32'h002081B3, 32'h320, 0, 0, 0);
    apply_stimulus(1, 32'h002081B3, 32'h324, 0, 0, 1);
    check_output("midstream_reset", {26'd0, id_valid, id_rd}, 32'd0);

    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      rst      = ($urandom_range(0, 99) == 0);
      flush    = ($urandom_range(0, 9) == 0);
      stall    = ($urandom_range(0, 4) == 0);
      if_valid = ($urandom_range(0, 7) != 0);
      if_inst  = rand_inst();
      if_pc    = $urandom & 32'hFFFF_FFFC;
    end
    @(negedge clk);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
